io_write_ctrl: RTL

Store-side MMIO decoder and peripheral command sequencer for the CPU data port. It sits beside the load-path read mux. It decodes CPU stores in the IO window (addr[14]=1) into LED/segment/SD/DDR2 registers and gates the DMEM write enable. It runs request/acknowledge/done handshakes to the SD and DDR2 controllers, stalls the pipeline on a command store to a busy channel, and produces the SD_Status/DDR2_Status words that the load path returns at 0x4014/0x4030.

---
 rtl/io_map_pkg.sv | 24 ++
 rtl/io_chan_fsm.sv | 79 +++++++
 rtl/io_write_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/io_map_pkg.sv
// io_map_pkg: store-side IO address map, command encodings and the
// per-channel sequencer state type shared by io_write_ctrl and io_chan_fsm.
package io_map_pkg;

  localparam logic [14:0] IO_SD_ADDR    = 15'h4010;
  localparam logic [14:0] IO_SD_CMD     = 15'h4018;
  localparam logic [14:0] IO_DDR2_ADDR  = 15'h4020;
  localparam logic [14:0] IO_DDR2_WDATA = 15'h4024;
  localparam logic [14:0] IO_DDR2_CMD   = 15'h4028;
  localparam logic [14:0] IO_LED        = 15'h4040;
  localparam logic [14:0] IO_SEG        = 15'h4044;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } chan_state_t;

endpackage

// File: rtl/io_chan_fsm.sv
// io_chan_fsm: one peripheral channel's req/ack/done sequencer.
// Ports: clk, rst, cmd_we/cmd (accepted command store), ack, op_done
// (controller handshake in), req, rw, busy, done, err (state out).
module io_chan_fsm
  import io_map_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_we,
  input  logic [1:0] cmd,
  input  logic       ack,
  input  logic       op_done,
  output logic       req,
  output logic       rw,
  output logic       busy,
  output logic       done,
  output logic       err
);

  chan_state_t state, state_d;
  logic        rw_d, done_d, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      rw    <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      rw    <= rw_d;
      done  <= done_d;
      err   <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    rw_d    = rw;
    done_d  = done;
    err_d   = err;
    unique case (state)
      ST_IDLE: begin
        if (cmd_we) begin
          if (cmd == CMD_RD || cmd == CMD_WR) begin
            state_d = ST_REQ;
            rw_d    = (cmd == CMD_WR);
            done_d  = 1'b0;
            err_d   = 1'b0;
          end else if (cmd == CMD_ILL) begin
            err_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // done alone is ignored here; only an ack can carry it
        if (ack) begin
          if (op_done) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (op_done) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req  = (state == ST_REQ);
  assign busy = (state != ST_IDLE);

endmodule

// File: rtl/io_write_ctrl.sv
// io_write_ctrl: IO-window store decoder, LED/SEG/SD/DDR2 registers,
// DMEM write gating, command stall and SD/DDR2 status words.
module io_write_ctrl
  import io_map_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        dmem_we,
  output logic        stall,
  output logic [15:0] led,
  output logic [31:0] seg,
  output logic [31:0] sd_addr,
  output logic        sd_req,
  output logic        sd_rw,
  input  logic        sd_ack,
  input  logic        sd_done,
  output logic [31:0] ddr2_addr,
  output logic [31:0] ddr2_wdata,
  output logic        ddr2_req,
  output logic        ddr2_rw,
  input  logic        ddr2_ack,
  input  logic        ddr2_done,
  output logic [31:0] sd_status,
  output logic [31:0] ddr2_status
);

  logic [14:0] a;
  logic        hit_sd_addr, hit_sd_cmd, hit_ddr_addr;
  logic        hit_ddr_wdata, hit_ddr_cmd, hit_led, hit_seg;
  logic        mapped;
  logic        sd_busy, sd_dn, sd_er;
  logic        dd_busy, dd_dn, dd_er;
  logic        addr_unused;

  // upper address bits do not take part in the IO decode
  assign a           = addr[14:0];
  assign addr_unused = ^addr[31:15];

  assign hit_sd_addr   = (a == IO_SD_ADDR);
  assign hit_sd_cmd    = (a == IO_SD_CMD);
  assign hit_ddr_addr  = (a == IO_DDR2_ADDR);
  assign hit_ddr_wdata = (a == IO_DDR2_WDATA);
  assign hit_ddr_cmd   = (a == IO_DDR2_CMD);
  assign hit_led       = (a == IO_LED);
  assign hit_seg       = (a == IO_SEG);

  assign mapped = hit_sd_addr | hit_sd_cmd | hit_ddr_addr
                | hit_ddr_wdata | hit_ddr_cmd | hit_led | hit_seg;

  assign dmem_we = we & ~mapped;
  assign stall   = we & ((hit_sd_cmd & sd_busy)
                       | (hit_ddr_cmd & dd_busy));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led        <= '0;
      seg        <= '0;
      sd_addr    <= '0;
      ddr2_addr  <= '0;
      ddr2_wdata <= '0;
    end else if (we) begin
      if (hit_led)       led        <= wdata[15:0];
      if (hit_seg)       seg        <= wdata;
      if (hit_sd_addr)   sd_addr    <= wdata;
      if (hit_ddr_addr)  ddr2_addr  <= wdata;
      if (hit_ddr_wdata) ddr2_wdata <= wdata;
    end
  end

  io_chan_fsm u_sd (
    .clk     (clk),
    .rst     (rst),
    .cmd_we  (we & hit_sd_cmd & ~sd_busy),
    .cmd     (wdata[1:0]),
    .ack     (sd_ack),
    .op_done (sd_done),
    .req     (sd_req),
    .rw      (sd_rw),
    .busy    (sd_busy),
    .done    (sd_dn),
    .err     (sd_er)
  );

  io_chan_fsm u_ddr2 (
    .clk     (clk),
    .rst     (rst),
    .cmd_we  (we & hit_ddr_cmd & ~dd_busy),
    .cmd     (wdata[1:0]),
    .ack     (ddr2_ack),
    .op_done (ddr2_done),
    .req     (ddr2_req),
    .rw      (ddr2_rw),
    .busy    (dd_busy),
    .done    (dd_dn),
    .err     (dd_er)
  );

  assign sd_status   = {29'b0, sd_er, sd_dn, sd_busy};
  assign ddr2_status = {29'b0, dd_er, dd_dn, dd_busy};

endmodule
